bus_interface: RTL and testbench

BUS_INTERFACE -- requirements
Module: bus_interface

---
 rtl/bus_interface_if.sv | 13 +
 rtl/bus_interface.sv | 132 +++++++++++++
 tb/tb_bus_interface.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bus_interface_if.sv
// Memory-side handshake bundle: request/write-enable/address/data out,
// read data and ready back from the memory.
interface bus_interface_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/bus_interface.sv
// Processor bus interface: AR/MDR/IR registers, a single outstanding memory
// access with wait-state timeout, and sticky error reporting.
module bus_interface #(
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    step,
    input  logic [1:0]              rec,
    input  logic                    wr,
    input  logic [15:0]             alu_out,
    input  logic [15:0]             wdata,
    bus_interface_if.master         mem,
    output logic [15:0]             ir,
    output logic [15:0]             mdr,
    output logic [15:0]             ar,
    output logic                    busy,
    output logic                    bus_err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] ERR   = 2'd3;

    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [15:0]   ar_q, ar_d;
    logic [15:0]   mdr_q, mdr_d;
    logic [15:0]   ir_q, ir_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          wr_pend_q, wr_pend_d;
    logic          err_q, err_d;
    logic          overrun_q, overrun_d;

    logic accept;
    logic launch;

    // IDLE and ERR both accept a fresh step; only READ/WRITE count as busy.
    assign accept = step && (state_q == IDLE || state_q == ERR);
    assign launch = accept && (rec[0] || !wr);

    always_comb begin
        state_d   = state_q;
        ar_d      = ar_q;
        mdr_d     = mdr_q;
        ir_d      = ir_q;
        wdata_d   = wdata_q;
        wait_d    = wait_q;
        wr_pend_d = wr_pend_q;
        err_d     = err_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE, ERR: begin
                if (accept) begin
                    state_d = IDLE;
                    wait_d  = '0;
                    if (rec == 2'b10) ir_d = mdr_q;
                    if (!wr) wdata_d = wdata;
                    if (rec[0]) begin
                        ar_d      = alu_out;
                        state_d   = READ;
                        wr_pend_d = !wr;
                    end else if (!wr) begin
                        state_d = WRITE;
                    end
                end
            end
            READ, WRITE: begin
                if (step) overrun_d = 1'b1;
                if (mem.ready) begin
                    wait_d = '0;
                    if (state_q == READ) begin
                        mdr_d     = mem.rdata;
                        // a write launched with the read follows back-to-back
                        state_d   = wr_pend_q ? WRITE : IDLE;
                        wr_pend_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    wait_d    = '0;
                    state_d   = ERR;
                    err_d     = 1'b1;
                    wr_pend_d = 1'b0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ar_q      <= '0;
            mdr_q     <= '0;
            ir_q      <= '0;
            wdata_q   <= '0;
            wait_q    <= '0;
            wr_pend_q <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ar_q      <= ar_d;
            mdr_q     <= mdr_d;
            ir_q      <= ir_d;
            wdata_q   <= wdata_d;
            wait_q    <= wait_d;
            wr_pend_q <= wr_pend_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
        end
    end

    // Request decoded from state so reset kills it without waiting for a clock.
    assign mem.req   = (state_q == READ) || (state_q == WRITE);
    assign mem.we    = (state_q == WRITE);
    assign mem.addr  = ar_q;
    assign mem.wdata = wdata_q;

    assign ir      = ir_q;
    assign mdr     = mdr_q;
    assign ar      = ar_q;
    assign busy    = mem.req || launch;
    assign bus_err = err_q || overrun_q;
endmodule

// File: tb/tb_bus_interface.sv
// Directed bench for bus_interface: fetch, store, combined, timeout,
// reset mid-write and overrun scenarios with hand-computed expectations.
module tb_bus_interface;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        step = 1'b0;
    logic [1:0]  rec = 2'b00;
    logic        wr = 1'b1;
    logic [15:0] alu_out = '0;
    logic [15:0] wdata = '0;
    logic [15:0] ir, mdr, ar;
    logic        busy, bus_err;
    int          nvec = 0;
    int          nerr = 0;

    bus_interface_if mif();

    bus_interface #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .step    (step),
        .rec     (rec),
        .wr      (wr),
        .alu_out (alu_out),
        .wdata   (wdata),
        .mem     (mif.master),
        .ir      (ir),
        .mdr     (mdr),
        .ar      (ar),
        .busy    (busy),
        .bus_err (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs just after the falling edge, settle, return.
    task automatic drv(input logic s, input logic [1:0] r, input logic w,
                       input logic [15:0] a, input logic [15:0] d,
                       input logic rdy, input logic [15:0] rd);
        @(negedge clk);
        step = s; rec = r; wr = w; alu_out = a; wdata = d;
        mif.ready = rdy; mif.rdata = rd;
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic rq, input logic we,
                           input logic [15:0] ad, input logic bz);
        chk({tag, "_req"},  16'(mif.req), 16'(rq));
        chk({tag, "_we"},   16'(mif.we),  16'(we));
        chk({tag, "_addr"}, mif.addr,     ad);
        chk({tag, "_busy"}, 16'(busy),    16'(bz));
    endtask

    task automatic chk_regs(input string tag, input logic [15:0] e_ir,
                            input logic [15:0] e_mdr, input logic [15:0] e_ar,
                            input logic e_err);
        chk({tag, "_ir"},  ir,  e_ir);
        chk({tag, "_mdr"}, mdr, e_mdr);
        chk({tag, "_ar"},  ar,  e_ar);
        chk({tag, "_err"}, 16'(bus_err), 16'(e_err));
    endtask

    initial begin
        mif.ready = 1'b0;
        mif.rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_bus("rst", 0, 0, 16'h0000, 0);
        chk_regs("rst", 16'h0000, 16'h0000, 16'h0000, 0);
        chk("rst_wdata", mif.wdata, 16'h0000);

        // Instruction fetch, step on the first edge after reset release
        @(negedge clk);
        reset = 1'b0; step = 1'b1; rec = 2'b01; alu_out = 16'h0040;
        #1;
        chk("f0_busy", 16'(busy), 16'h1);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 0, 16'h0);
        chk_bus("f1", 1, 0, 16'h0040, 1);
        chk("f1_ar", ar, 16'h0040);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 0, 16'h0);
        chk_bus("f2", 1, 0, 16'h0040, 1);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 1, 16'h0123);
        chk_bus("f3", 1, 0, 16'h0040, 1);
        chk("f3_mdr", mdr, 16'h0000);
        drv(1, 2'b10, 1, 16'h0, 16'h0, 0, 16'h0);
        chk_bus("f4", 0, 0, 16'h0040, 0);
        chk_regs("f4", 16'h0000, 16'h0123, 16'h0040, 0);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 0, 16'h0);
        chk_regs("f5", 16'h0123, 16'h0123, 16'h0040, 0);

        // Store to 0x0100: first point AR there with a read
        drv(1, 2'b01, 1, 16'h0100, 16'h0, 0, 16'h0);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 1, 16'h5555);
        drv(1, 2'b00, 0, 16'h0, 16'hBEEF, 0, 16'h0);
        chk("s0_busy", 16'(busy), 16'h1);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 1, 16'h0);
        chk_bus("s1", 1, 1, 16'h0100, 1);
        chk("s1_wdata", mif.wdata, 16'hBEEF);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 0, 16'h0);
        chk_bus("s2", 0, 0, 16'h0100, 0);
        chk_regs("s2", 16'h0123, 16'h5555, 16'h0100, 0);

        // Combined read then write at 0xFFFF
        drv(1, 2'b11, 0, 16'hFFFF, 16'hA5A5, 0, 16'h0);
        chk("c0_busy", 16'(busy), 16'h1);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 1, 16'h1111);
        chk_bus("c1", 1, 0, 16'hFFFF, 1);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 0, 16'h0);
        chk_bus("c2", 1, 1, 16'hFFFF, 1);
        chk("c2_wdata", mif.wdata, 16'hA5A5);
        chk("c2_mdr", mdr, 16'h1111);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 1, 16'h0);
        chk_bus("c3", 1, 1, 16'hFFFF, 1);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 0, 16'h0);
        chk_bus("c4", 0, 0, 16'hFFFF, 0);
        chk_regs("c4", 16'h0123, 16'h1111, 16'hFFFF, 0);

        // Timeout after 4 wait cycles
        drv(1, 2'b11, 1, 16'h0300, 16'h0, 0, 16'h0);
        for (int i = 1; i <= 4; i++) begin
            drv(0, 2'b00, 1, 16'h0, 16'h0, 0, 16'h0);
            chk_bus($sformatf("t%0d", i), 1, 0, 16'h0300, 1);
            chk($sformatf("t%0d_err", i), 16'(bus_err), 16'h0);
        end
        drv(0, 2'b00, 1, 16'h0, 16'h0, 1, 16'h9999);
        chk_bus("t5", 0, 0, 16'h0300, 0);
        chk("t5_err", 16'(bus_err), 16'h1);
        drv(1, 2'b01, 1, 16'h0400, 16'h0, 0, 16'h0);
        chk("t6_mdr", mdr, 16'h1111);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 1, 16'h2222);
        chk_bus("t7", 1, 0, 16'h0400, 1);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 0, 16'h0);
        chk_bus("t8", 0, 0, 16'h0400, 0);
        chk_regs("t8", 16'h0123, 16'h2222, 16'h0400, 1);

        // Reset in the middle of a write
        drv(1, 2'b00, 0, 16'h0, 16'h1234, 0, 16'h0);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 0, 16'h0);
        chk_bus("w1", 1, 1, 16'h0400, 1);
        reset = 1'b1;
        #1;
        chk_bus("wr", 0, 0, 16'h0000, 0);
        chk_regs("wr", 16'h0000, 16'h0000, 16'h0000, 0);
        chk("wr_wdata", mif.wdata, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Overrun: rec=10 while a read is pending
        drv(1, 2'b01, 1, 16'h0500, 16'h0, 0, 16'h0);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 1, 16'h0ABC);
        drv(1, 2'b10, 1, 16'h0, 16'h0, 0, 16'h0);
        drv(1, 2'b01, 1, 16'h0600, 16'h0, 0, 16'h0);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 1, 16'h0DEF);
        drv(1, 2'b01, 1, 16'h0200, 16'h0, 0, 16'h0);
        chk_regs("o0", 16'h0ABC, 16'h0DEF, 16'h0600, 0);
        drv(1, 2'b10, 1, 16'h0, 16'h0, 0, 16'h0);
        chk_bus("o1", 1, 0, 16'h0200, 1);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 1, 16'h7777);
        chk_bus("o2", 1, 0, 16'h0200, 1);
        chk_regs("o2", 16'h0ABC, 16'h0DEF, 16'h0200, 1);
        drv(0, 2'b00, 1, 16'h0, 16'h0, 0, 16'h0);
        chk_bus("o3", 0, 0, 16'h0200, 0);
        chk_regs("o3", 16'h0ABC, 16'h7777, 16'h0200, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
